lives_hud_renderer: RTL and testbench

- Next-generation HUD lives block for the VGA pipeline.
- Owns the lives counter and takes hit/bonus events from game logic.
- Renders a parametrised row of life icons from an external synchronous sprite ROM.
- Blinks the icon of a just-lost life for a fixed number of frames.
- Outputs a registered RGB pixel plus an opaque-hit flag for the downstream layer mixer. Total latency from h_count/v_count is 2 clocks.

---
 rtl/hud_pkg.sv | 47 ++++
 rtl/lives_fsm.sv | 97 +++++++++
 rtl/lives_hud_renderer.sv | 153 +++++++++++++++
 tb/tb_lives_hud_renderer.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hud_pkg.sv
// Shared definitions for the lives HUD: screen bounds, the 6-bit RRGGBB
// sprite format with its full/dim expansions to 3-bit channels, the lives FSM
// state encoding and the per-pixel draw mode.
package hud_pkg;

   localparam int unsigned SCREEN_W = 640;
   localparam int unsigned SCREEN_H = 480;

   typedef logic [5:0] sprite_t;

   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [2:0] b;
   } rgb_t;

   typedef enum logic [1:0] {
      StAlive = 2'd0,
      StBlink = 2'd1,
      StOver  = 2'd2
   } lives_state_e;

   typedef enum logic [1:0] {
      ModeNone = 2'd0,
      ModeDim  = 2'd1,
      ModeFull = 2'd2
   } pix_mode_e;

   // Full brightness: the 2-bit channel lands in the top bits.
   function automatic rgb_t expand_full(sprite_t c);
      rgb_t o;
      o.r = {c[5:4], 1'b0};
      o.g = {c[3:2], 1'b0};
      o.b = {c[1:0], 1'b0};
      return o;
   endfunction

   // Half brightness: same channel shifted down one bit.
   function automatic rgb_t expand_dim(sprite_t c);
      rgb_t o;
      o.r = {1'b0, c[5:4]};
      o.g = {1'b0, c[3:2]};
      o.b = {1'b0, c[1:0]};
      return o;
   endfunction

endpackage

// File: rtl/lives_fsm.sv
// Lives counter and blink/game-over state machine.
// Ports:
//   clk, rst                 pixel clock, synchronous active-high reset
//   frame_tick               one-cycle pulse per frame, advances the blink counter
//   life_lost, life_gained   one-cycle game events
//   restart                  reload START_LIVES, return to ALIVE
//   lives                    current lives count
//   blink_idx                slot of the most recently lost life
//   in_blink                 FSM is in BLINK
//   blink_on                 lost slot is in the lit half of its blink cycle
//   game_over                FSM is in OVER
module lives_fsm
   import hud_pkg::*;
#(
   parameter int unsigned MAX_LIVES    = 3,
   parameter int unsigned START_LIVES  = 3,
   parameter int unsigned BLINK_FRAMES = 60,
   parameter int unsigned BLINK_PERIOD = 8,
   localparam int unsigned LW = $clog2(MAX_LIVES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_tick,
   input  logic          life_lost,
   input  logic          life_gained,
   input  logic          restart,
   output logic [LW-1:0] lives,
   output logic [LW-1:0] blink_idx,
   output logic          in_blink,
   output logic          blink_on,
   output logic          game_over
);

   localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [FW-1:0] LastFrame = FW'(BLINK_FRAMES - 1);

   lives_state_e  state_q, state_d;
   logic [LW-1:0] lives_q, lives_d;
   logic [LW-1:0] blink_idx_q, blink_idx_d;
   logic [FW-1:0] frame_cnt_q, frame_cnt_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= StAlive;
         lives_q     <= LW'(START_LIVES);
         blink_idx_q <= '0;
         frame_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         lives_q     <= lives_d;
         blink_idx_q <= blink_idx_d;
         frame_cnt_q <= frame_cnt_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      lives_d     = lives_q;
      blink_idx_d = blink_idx_q;
      frame_cnt_d = frame_cnt_q;
      if (restart) begin
         state_d     = StAlive;
         lives_d     = LW'(START_LIVES);
         blink_idx_d = '0;
         frame_cnt_d = '0;
      end else if (state_q != StOver) begin
         if (life_lost && !life_gained && lives_q != '0) begin
            // A new loss always restarts the blink on the freshly emptied slot.
            lives_d     = lives_q - LW'(1);
            blink_idx_d = lives_q - LW'(1);
            frame_cnt_d = '0;
            state_d     = StBlink;
         end else begin
            if (life_gained && !life_lost && lives_q < LW'(MAX_LIVES)) begin
               lives_d = lives_q + LW'(1);
            end
            if (state_q == StBlink && frame_tick) begin
               if (frame_cnt_q == LastFrame) begin
                  frame_cnt_d = '0;
                  state_d     = (lives_d == '0) ? StOver : StAlive;
               end else begin
                  frame_cnt_d = frame_cnt_q + FW'(1);
               end
            end
         end
      end
   end

   always_comb begin
      lives     = lives_q;
      blink_idx = blink_idx_q;
      in_blink  = (state_q == StBlink);
      game_over = (state_q == StOver);
      blink_on  = (((32'(frame_cnt_q) / BLINK_PERIOD) % 2) == 0);
   end

endmodule

// File: rtl/lives_hud_renderer.sv
// HUD lives block: a row of MAX_LIVES life icons drawn from an external
// synchronous sprite ROM, with the just-lost icon blinking.
// Ports:
//   clk, rst                        pixel clock, synchronous active-high reset
//   frame_tick, life_lost,
//   life_gained, restart            frame pulse and game events (see lives_fsm)
//   h_count, v_count                current pixel position
//   rom_x, rom_y                    sprite address (combinational from h/v)
//   rom_data                        RRGGBB sprite data, one clock after address
//   lives, game_over                lives state
//   hud_hit                         registered: output pixel is opaque HUD
//   vga_r, vga_g, vga_b             registered colour, 2 clocks after h/v
module lives_hud_renderer
   import hud_pkg::*;
#(
   parameter int unsigned MAX_LIVES    = 3,
   parameter int unsigned START_LIVES  = 3,
   parameter int unsigned ICON_W       = 16,
   parameter int unsigned ICON_H       = 16,
   parameter int unsigned SPACING      = 8,
   parameter int unsigned X_START      = 160,
   parameter int unsigned Y_START      = 440,
   parameter int unsigned BLINK_FRAMES = 60,
   parameter int unsigned BLINK_PERIOD = 8,
   parameter bit          SHOW_EMPTY   = 1'b1,
   parameter logic [5:0]  TRANSPARENT  = 6'b000000,
   localparam int unsigned XW = $clog2(ICON_W),
   localparam int unsigned YW = $clog2(ICON_H),
   localparam int unsigned LW = $clog2(MAX_LIVES + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          frame_tick,
   input  logic          life_lost,
   input  logic          life_gained,
   input  logic          restart,
   input  logic [9:0]    h_count,
   input  logic [9:0]    v_count,
   output logic [XW-1:0] rom_x,
   output logic [YW-1:0] rom_y,
   input  logic [5:0]    rom_data,
   output logic [LW-1:0] lives,
   output logic          game_over,
   output logic          hud_hit,
   output logic [2:0]    vga_r,
   output logic [2:0]    vga_g,
   output logic [2:0]    vga_b
);

   localparam int unsigned PITCH = ICON_W + SPACING;

   if (X_START + MAX_LIVES * PITCH > SCREEN_W) begin : g_chk_x
      $error("lives_hud_renderer: icon row runs past the screen width");
   end
   if (Y_START + ICON_H > SCREEN_H) begin : g_chk_y
      $error("lives_hud_renderer: icon row runs past the screen height");
   end

   logic [LW-1:0] blink_idx;
   logic          in_blink;
   logic          blink_on;

   lives_fsm #(
      .MAX_LIVES   (MAX_LIVES),
      .START_LIVES (START_LIVES),
      .BLINK_FRAMES(BLINK_FRAMES),
      .BLINK_PERIOD(BLINK_PERIOD)
   ) u_lives_fsm (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .life_lost  (life_lost),
      .life_gained(life_gained),
      .restart    (restart),
      .lives      (lives),
      .blink_idx  (blink_idx),
      .in_blink   (in_blink),
      .blink_on   (blink_on),
      .game_over  (game_over)
   );

   // Stage 0: slot hit test and sprite address.
   logic          hit0;
   logic [LW-1:0] idx0;
   pix_mode_e     mode0;

   always_comb begin
      hit0  = 1'b0;
      idx0  = '0;
      rom_x = '0;
      rom_y = '0;
      if (32'(v_count) >= Y_START && 32'(v_count) < Y_START + ICON_H) begin
         for (int unsigned i = 0; i < MAX_LIVES; i++) begin
            if (32'(h_count) >= X_START + i * PITCH &&
                32'(h_count) < X_START + i * PITCH + ICON_W) begin
               hit0  = 1'b1;
               idx0  = LW'(i);
               rom_x = XW'(32'(h_count) - (X_START + i * PITCH));
               rom_y = YW'(32'(v_count) - Y_START);
            end
         end
      end
   end

   always_comb begin
      if (idx0 < lives) begin
         mode0 = ModeFull;
      end else if (in_blink && idx0 == blink_idx && blink_on) begin
         mode0 = ModeFull;
      end else if (SHOW_EMPTY) begin
         mode0 = ModeDim;
      end else begin
         mode0 = ModeNone;
      end
   end

   // Stage 1: align hit/mode with the ROM read launched in stage 0.
   logic      hit1;
   pix_mode_e mode1;

   always_ff @(posedge clk) begin
      if (rst) begin
         hit1  <= 1'b0;
         mode1 <= ModeNone;
      end else begin
         hit1  <= hit0;
         mode1 <= mode0;
      end
   end

   // Stage 2: colour out.
   always_ff @(posedge clk) begin
      if (rst) begin
         hud_hit <= 1'b0;
         vga_r   <= '0;
         vga_g   <= '0;
         vga_b   <= '0;
      end else if (hit1 && mode1 != ModeNone && rom_data != TRANSPARENT) begin
         hud_hit <= 1'b1;
         if (mode1 == ModeFull) begin
            {vga_r, vga_g, vga_b} <= expand_full(rom_data);
         end else begin
            {vga_r, vga_g, vga_b} <= expand_dim(rom_data);
         end
      end else begin
         hud_hit <= 1'b0;
         vga_r   <= '0;
         vga_g   <= '0;
         vga_b   <= '0;
      end
   end

endmodule

// File: tb/tb_lives_hud_renderer.sv
// Self-checking bench for lives_hud_renderer with default parameters.
// Pixel expectations go through a scoreboard queue: pushed when a position is
// driven, popped when the 2-clock pipeline delivers the matching output.
module tb_lives_hud_renderer;

   logic       clk = 1'b0;
   logic       rst;
   logic       frame_tick;
   logic       life_lost;
   logic       life_gained;
   logic       restart;
   logic [9:0] h_count;
   logic [9:0] v_count;
   logic [3:0] rom_x;
   logic [3:0] rom_y;
   logic [5:0] rom_data;
   logic [5:0] rom_val;
   logic [1:0] lives;
   logic       game_over;
   logic       hud_hit;
   logic [2:0] vga_r;
   logic [2:0] vga_g;
   logic [2:0] vga_b;

   int checks   = 0;
   int failures = 0;

   // {hud_hit, r, g, b}
   logic [9:0] sb[$];
   localparam logic [9:0] PxFull = {1'b1, 3'd6, 3'd0, 3'd0};
   localparam logic [9:0] PxDim  = {1'b1, 3'd3, 3'd0, 3'd0};
   localparam logic [9:0] PxNone = 10'd0;

   lives_hud_renderer dut (
      .clk        (clk),
      .rst        (rst),
      .frame_tick (frame_tick),
      .life_lost  (life_lost),
      .life_gained(life_gained),
      .restart    (restart),
      .h_count    (h_count),
      .v_count    (v_count),
      .rom_x      (rom_x),
      .rom_y      (rom_y),
      .rom_data   (rom_data),
      .lives      (lives),
      .game_over  (game_over),
      .hud_hit    (hud_hit),
      .vga_r      (vga_r),
      .vga_g      (vga_g),
      .vga_b      (vga_b)
   );

   always #5 clk = ~clk;

   // Synchronous sprite ROM: every address returns rom_val.
   always @(posedge clk) rom_data <= rom_val;

   task automatic set_pix(input int unsigned h, input int unsigned v);
      @(negedge clk);
      h_count = 10'(h);
      v_count = 10'(v);
   endtask

   task automatic pulse(input logic l, input logic g, input logic r);
      @(negedge clk);
      life_lost   = l;
      life_gained = g;
      restart     = r;
      @(negedge clk);
      life_lost   = 1'b0;
      life_gained = 1'b0;
      restart     = 1'b0;
   endtask

   task automatic tick_frames(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         frame_tick = 1'b1;
         @(negedge clk);
         frame_tick = 1'b0;
      end
   endtask

   task automatic test_reset;
      logic [9:0] got;
      rst = 1'b1;
      repeat (3) @(negedge clk);
      got = {hud_hit, vga_r, vga_g, vga_b};
      checks++;
      if (lives !== 2'd3) begin
         failures++;
         $display("FAIL reset_lives got=%0d exp=3", lives);
      end
      checks++;
      if (game_over !== 1'b0 || got !== PxNone) begin
         failures++;
         $display("FAIL reset_outputs game_over=%b pix=%h exp 0/000", game_over, got);
      end
      rst = 1'b0;
   endtask

   task automatic test_pixels;
      int unsigned ph[11] = '{168, 100, 168, 159, 160, 175, 176, 160, 184, 223, 224};
      int unsigned pv[11] = '{448, 448, 400, 448, 440, 455, 448, 456, 450, 455, 448};
      logic [9:0]  pe[11] = '{PxFull, PxNone, PxNone, PxNone, PxFull, PxFull, PxNone,
                              PxNone, PxFull, PxFull, PxNone};
      logic [9:0]  got, exp;
      for (int i = 0; i < 11; i++) begin
         set_pix(ph[i], pv[i]);
         sb.push_back(pe[i]);
         repeat (2) @(negedge clk);
         got = {hud_hit, vga_r, vga_g, vga_b};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL pixel(%0d,%0d) got=%h exp=%h", ph[i], pv[i], got, exp);
         end
      end
   endtask

   task automatic test_back_to_back;
      logic [9:0] got, exp;
      logic       in_slot;
      for (int h = 150; h < 232; h++) begin
         @(negedge clk);
         if (sb.size() >= 2) begin
            got = {hud_hit, vga_r, vga_g, vga_b};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL stream h=%0d got=%h exp=%h", h - 2, got, exp);
            end
         end
         h_count = 10'(h);
         v_count = 10'd448;
         in_slot = 1'b0;
         for (int s = 0; s < 3; s++) begin
            if (h >= 160 + 24 * s && h < 176 + 24 * s) in_slot = 1'b1;
         end
         sb.push_back(in_slot ? PxFull : PxNone);
      end
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         got = {hud_hit, vga_r, vga_g, vga_b};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL stream_tail %0d got=%h exp=%h", k, got, exp);
         end
      end
   endtask

   task automatic test_transparent;
      logic [9:0] got, exp;
      rom_val = 6'b000000;
      set_pix(168, 448);
      sb.push_back(PxNone);
      #1;
      checks++;
      if (rom_x !== 4'd8 || rom_y !== 4'd8) begin
         failures++;
         $display("FAIL rom_addr_slot0 got=(%0d,%0d) exp=(8,8)", rom_x, rom_y);
      end
      repeat (2) @(negedge clk);
      got = {hud_hit, vga_r, vga_g, vga_b};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL transparent got=%h exp=%h", got, exp);
      end
      set_pix(190, 450);
      #1;
      checks++;
      if (rom_x !== 4'd6 || rom_y !== 4'd10) begin
         failures++;
         $display("FAIL rom_addr_slot1 got=(%0d,%0d) exp=(6,10)", rom_x, rom_y);
      end
      set_pix(100, 448);
      #1;
      checks++;
      if (rom_x !== 4'd0 || rom_y !== 4'd0) begin
         failures++;
         $display("FAIL rom_addr_outside got=(%0d,%0d) exp=(0,0)", rom_x, rom_y);
      end
      rom_val = 6'b110000;
   endtask

   // Blink of slot 2: per step, frames to advance then expected slot-2 pixel.
   task automatic test_blink;
      int         adv[7] = '{0, 8, 8, 32, 11, 1, 8};
      logic [9:0] pe[7]  = '{PxFull, PxDim, PxFull, PxFull, PxDim, PxDim, PxDim};
      logic [9:0] got, exp;
      pulse(1'b1, 1'b0, 1'b0);
      checks++;
      if (lives !== 2'd2) begin
         failures++;
         $display("FAIL blink_lives got=%0d exp=2", lives);
      end
      for (int i = 0; i < 7; i++) begin
         tick_frames(adv[i]);
         set_pix(216, 448);
         sb.push_back(pe[i]);
         repeat (2) @(negedge clk);
         got = {hud_hit, vga_r, vga_g, vga_b};
         exp = sb.pop_front();
         checks++;
         if (got !== exp) begin
            failures++;
            $display("FAIL blink_step%0d got=%h exp=%h", i, got, exp);
         end
         if (i == 1) begin
            set_pix(190, 448);
            sb.push_back(PxFull);
            repeat (2) @(negedge clk);
            got = {hud_hit, vga_r, vga_g, vga_b};
            exp = sb.pop_front();
            checks++;
            if (got !== exp) begin
               failures++;
               $display("FAIL blink_slot1 got=%h exp=%h", got, exp);
            end
         end
      end
   endtask

   task automatic test_both_events;
      logic [9:0] got, exp;
      pulse(1'b1, 1'b1, 1'b0);
      checks++;
      if (lives !== 2'd2) begin
         failures++;
         $display("FAIL both_lives got=%0d exp=2", lives);
      end
      set_pix(216, 448);
      sb.push_back(PxDim);
      repeat (2) @(negedge clk);
      got = {hud_hit, vga_r, vga_g, vga_b};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL both_no_blink got=%h exp=%h", got, exp);
      end
      pulse(1'b0, 1'b1, 1'b0);
      checks++;
      if (lives !== 2'd3) begin
         failures++;
         $display("FAIL gain_lives got=%0d exp=3", lives);
      end
      pulse(1'b0, 1'b1, 1'b0);
      checks++;
      if (lives !== 2'd3) begin
         failures++;
         $display("FAIL gain_ceiling got=%0d exp=3", lives);
      end
   endtask

   task automatic test_game_over;
      logic [9:0] got, exp;
      for (int n = 0; n < 3; n++) begin
         pulse(1'b1, 1'b0, 1'b0);
         checks++;
         if (lives !== 2'(2 - n)) begin
            failures++;
            $display("FAIL over_loss%0d got=%0d exp=%0d", n, lives, 2 - n);
         end
         tick_frames(3);
      end
      // Last loss restarted the counter; 3 ticks already elapsed.
      tick_frames(56);
      checks++;
      if (game_over !== 1'b0) begin
         failures++;
         $display("FAIL over_early got=%b exp=0", game_over);
      end
      tick_frames(1);
      checks++;
      if (game_over !== 1'b1) begin
         failures++;
         $display("FAIL over_set got=%b exp=1", game_over);
      end
      pulse(1'b1, 1'b0, 1'b0);
      pulse(1'b0, 1'b1, 1'b0);
      checks++;
      if (lives !== 2'd0 || game_over !== 1'b1) begin
         failures++;
         $display("FAIL over_ignore lives=%0d go=%b exp 0/1", lives, game_over);
      end
      set_pix(168, 448);
      sb.push_back(PxDim);
      repeat (2) @(negedge clk);
      got = {hud_hit, vga_r, vga_g, vga_b};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL over_slot0 got=%h exp=%h", got, exp);
      end
      pulse(1'b0, 1'b0, 1'b1);
      checks++;
      if (lives !== 2'd3 || game_over !== 1'b0) begin
         failures++;
         $display("FAIL restart lives=%0d go=%b exp 3/0", lives, game_over);
      end
   endtask

   task automatic test_reset_mid_blink;
      logic [9:0] got, exp;
      pulse(1'b1, 1'b0, 1'b0);
      tick_frames(3);
      set_pix(168, 448);
      repeat (2) @(negedge clk);
      rst       = 1'b1;
      life_lost = 1'b1;
      @(negedge clk);
      got = {hud_hit, vga_r, vga_g, vga_b};
      checks++;
      if (lives !== 2'd3 || game_over !== 1'b0 || got !== PxNone) begin
         failures++;
         $display("FAIL reset_mid_blink lives=%0d go=%b pix=%h exp 3/0/000",
                  lives, game_over, got);
      end
      rst       = 1'b0;
      life_lost = 1'b0;
      set_pix(216, 448);
      sb.push_back(PxFull);
      repeat (2) @(negedge clk);
      got = {hud_hit, vga_r, vga_g, vga_b};
      exp = sb.pop_front();
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL post_reset_slot2 got=%h exp=%h", got, exp);
      end
   endtask

   initial begin
      rst         = 1'b1;
      frame_tick  = 1'b0;
      life_lost   = 1'b0;
      life_gained = 1'b0;
      restart     = 1'b0;
      h_count     = 10'd0;
      v_count     = 10'd0;
      rom_val     = 6'b110000;
      test_reset();
      test_pixels();
      test_back_to_back();
      test_transparent();
      test_blink();
      test_both_events();
      test_game_over();
      test_reset_mid_blink();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
